// File: rtl/program_mem_loader.sv
// program_mem_loader: zero-clearing instruction store with 1-cycle fetch and byte-wide run-time loader.
// Define PMEM_PARITY_EN to add a per-word even-parity bit checked on fetch.
module program_mem_loader #(
    parameter int PC_WIDTH = 8,
    parameter int IR_WIDTH = 16,
    parameter int CMD_CNT  = 64
) (
    input  logic                clk,
    input  logic                res,
    input  logic                load_req,
    input  logic [7:0]          ld_data,
    input  logic                ld_valid,
    input  logic                ld_last,
    output logic                ld_ready,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                fetch_en,
    output logic [IR_WIDTH-1:0] ir,
    output logic                ir_valid,
    output logic                busy,
    output logic                load_ovf,
    output logic                parity_err
);
    localparam int NB = IR_WIDTH / 8;
    localparam int AW = CMD_CNT > 1 ? $clog2(CMD_CNT) : 1;
    localparam int BW = $clog2(NB) + 1;
    localparam logic [AW-1:0] LAST = AW'(CMD_CNT - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;
    state_t state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [IR_WIDTH-1:0] acc, acc_n, asm_word, wdata;
    logic we, fetch, ovf_set, in_range;
    logic [IR_WIDTH-1:0] mem [CMD_CNT];

    assign ld_ready = state == LOAD;
    assign busy     = state != IDLE;
    assign in_range = {1'b0, pc} < (PC_WIDTH + 1)'(CMD_CNT);
    // Bytes land MSB-first; unfilled low bytes stay 0, which doubles as ld_last padding.
    assign asm_word = acc | (IR_WIDTH'(ld_data) << (8 * (NB - 1 - int'(bcnt))));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        bcnt_n  = bcnt;
        acc_n   = acc;
        we      = 1'b0;
        wdata   = asm_word;
        fetch   = 1'b0;
        ovf_set = 1'b0;
        case (state)
            CLEAR: begin
                we      = 1'b1;
                wdata   = '0;
                ptr_n   = ptr == LAST ? '0 : ptr + AW'(1);
                state_n = ptr == LAST ? IDLE : CLEAR;
            end
            IDLE: begin
                fetch   = fetch_en & ~load_req;
                state_n = load_req ? LOAD : IDLE;
                ptr_n   = load_req ? '0 : ptr;
                bcnt_n  = load_req ? '0 : bcnt;
                acc_n   = load_req ? '0 : acc;
            end
            LOAD: begin
                if (ld_valid) begin
                    if (bcnt == BW'(NB - 1) || ld_last) begin
                        we      = 1'b1;
                        ptr_n   = ptr + AW'(1);
                        bcnt_n  = '0;
                        acc_n   = '0;
                        ovf_set = ~ld_last & (ptr == LAST);
                        state_n = (ld_last || ptr == LAST) ? IDLE : LOAD;
                    end else begin
                        bcnt_n = bcnt + BW'(1);
                        acc_n  = asm_word;
                    end
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state    <= CLEAR;
            ptr      <= '0;
            bcnt     <= '0;
            acc      <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            load_ovf <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            bcnt     <= bcnt_n;
            acc      <= acc_n;
            ir_valid <= fetch;
            ir       <= fetch ? (in_range ? mem[pc[AW-1:0]] : '0) : ir;
            load_ovf <= load_ovf | ovf_set;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !res)
            mem[ptr] <= wdata;
    end

`ifdef PMEM_PARITY_EN
    logic par [CMD_CNT];
    always_ff @(posedge clk) begin
        if (we && !res)
            par[ptr] <= ^wdata;
    end
    always_ff @(posedge clk) begin
        if (res)
            parity_err <= 1'b0;
        else if (fetch && in_range && (^mem[pc[AW-1:0]] != par[pc[AW-1:0]]))
            parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_program_mem_loader.sv
// tb_program_mem_loader: directed checks of clear, load, overflow, fetch and reset-abort.
module tb_program_mem_loader;
    logic        clk = 1'b0;
    logic        res, load_req, ld_valid, ld_last, fetch_en;
    logic [7:0]  ld_data, pc;
    logic        ld_ready, ir_valid, busy, load_ovf, parity_err;
    logic [15:0] ir;
    int total = 0;
    int bad = 0;

    program_mem_loader dut (
        .clk(clk), .res(res), .load_req(load_req), .ld_data(ld_data),
        .ld_valid(ld_valid), .ld_last(ld_last), .ld_ready(ld_ready),
        .pc(pc), .fetch_en(fetch_en), .ir(ir), .ir_valid(ir_valid),
        .busy(busy), .load_ovf(load_ovf), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_data  = b;
        ld_valid = 1'b1;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a, input logic [15:0] exp, input string tag);
        pc       = a;
        fetch_en = 1'b1;
        tick();
        chk(tag, ir, exp);
        chk({tag, "_v"}, ir_valid, 1);
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            chk({tag, "_rdy"}, ld_ready, 0);
            tick();
            n++;
        end
        chk(tag, n, 64);
    endtask

    initial begin
        int acc_cnt;
        res = 1'b1; load_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        ld_data = '0; pc = '0; fetch_en = 1'b0;
        repeat (3) tick();
        chk("rst_ir", ir, 0);
        chk("rst_irv", ir_valid, 0);
        chk("rst_rdy", ld_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ovf", load_ovf, 0);
        chk("rst_par", parity_err, 0);
        res = 1'b0;
        count_busy("clear_len");
        fetch(8'd5, 16'h0000, "fetch5");
        fetch_en = 1'b0;
        tick();
        chk("irv_drop", ir_valid, 0);

        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        chk("ld_rdy", ld_ready, 1);
        chk("ld_busy", busy, 1);
        send(8'h49, 0); send(8'h03, 0); send(8'h4A, 0); send(8'h14, 1);
        chk("ld_done_rdy", ld_ready, 0);
        chk("ld_done_busy", busy, 0);
        fetch(8'd0, 16'h4903, "f0");
        fetch(8'd1, 16'h4A14, "f1");
        fetch_en = 1'b0;
        tick();
        chk("hold_ir", ir, 16'h4A14);
        chk("hold_v", ir_valid, 0);

        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        send(8'h12, 0); tick(); send(8'h34, 0); tick(); tick(); send(8'hAB, 1);
        chk("pad_rdy", ld_ready, 0);
        fetch(8'd0, 16'h1234, "p0");
        fetch(8'd1, 16'hAB00, "p1");
        fetch(8'd2, 16'h0000, "p2");
        fetch_en = 1'b0;

        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 130; k++) begin
            ld_data  = 8'(k);
            ld_valid = 1'b1;
            if (ld_ready) acc_cnt++;
            tick();
            if (k == 127) begin
                chk("ovf_set", load_ovf, 1);
                chk("ovf_rdy", ld_ready, 0);
            end
        end
        ld_valid = 1'b0;
        chk("ovf_acc", acc_cnt, 128);
        chk("ovf_busy", busy, 0);
        fetch(8'd200, 16'h0000, "oor");
        fetch(8'd63, 16'h7E7F, "o63");
        fetch(8'd10, 16'h1415, "o10");
        fetch_en = 1'b0;
        tick();
        chk("ovf_sticky", load_ovf, 1);

        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        res = 1'b1;
        tick();
        chk("rr_ovf", load_ovf, 0);
        chk("rr_rdy", ld_ready, 0);
        chk("rr_busy", busy, 1);
        res = 1'b0;
        count_busy("rr_len");
        for (int a = 0; a < 64; a++)
            fetch(8'(a), 16'h0000, "rr_zero");
        fetch_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/program_mem_loader.md
# program_mem_loader

Parametrised successor to the fixed-content program memory. It holds a CMD_CNT × IR_WIDTH instruction store that the core fetches from with one-cycle registered latency. After reset it zero-clears itself, and a byte-wide valid/ready loader writes new programs at run time. It sits between the external boot/debug byte source and the core's PC/IR fetch path.

## Interface
- PC_WIDTH, 8: program counter width; requires CMD_CNT ≤ 2^PC_WIDTH.
- IR_WIDTH, 16: instruction width; must be a multiple of 8.
- CMD_CNT, 64: number of instruction words.
- clk  input  1  single clock; all logic on rising edge.
- res  input  1  reset, synchronous, active-high.
- load_req  input  1  one-cycle request to start a load session; honoured only in IDLE.
- ld_data  input  8  loader byte.
- ld_valid  input  1  ld_data valid.
- ld_last  input  1  qualifies the final byte of a session.
- ld_ready  output  1  loader accepts a byte this cycle.
- pc  input  PC_WIDTH  fetch address.
- fetch_en  input  1  fetch request.
- ir  output  IR_WIDTH  fetched instruction (registered).
- ir_valid  output  1  ir was updated by a fetch on the previous cycle.
- busy  output  1  store is in CLEAR or LOAD; no fetches are served.
- load_ovf  output  1  sticky: a load exceeded CMD_CNT words.
- parity_err  output  1  sticky parity error (only with PMEM_PARITY_EN; otherwise tied 0).

## Operation
- States: CLEAR, IDLE, LOAD. Reset forces CLEAR, from any state.
- **CLEAR**
  - Clear pointer walks 0..CMD_CNT-1 and writes 0 to one word per cycle.
  - After writing address CMD_CNT-1, go to IDLE. CLEAR lasts exactly CMD_CNT cycles.
  - load_req and fetch_en are ignored (not queued).
- **IDLE**
  - fetch_en=1: ir <= mem[pc] and ir_valid <= 1. If pc ≥ CMD_CNT, ir <= 0 (NOP).
  - fetch_en=0: ir holds and ir_valid <= 0.
  - load_req=1 takes priority over a simultaneous fetch: go to LOAD, clear the write pointer and byte count, and drive ir_valid <= 0.
- **LOAD**
  - ld_ready=1. A byte is accepted on ld_valid & ld_ready.
  - Bytes assemble MSB-first: the first byte goes to ir bits [IR_WIDTH-1:IR_WIDTH-8].
  - When IR_WIDTH/8 bytes are assembled, write the word at the write pointer and increment the pointer.
  - If an accepted byte carries ld_last and the word is incomplete, pad the remaining low bytes with 0, write the word, and go to IDLE.
  - If ld_last completes a word exactly, write the word and go to IDLE.
  - Words not written in a session keep their previous contents.
  - Overflow: once word CMD_CNT-1 is written and ld_last has not arrived, set load_ovf, go to IDLE, and drop ld_ready. Later bytes are not accepted.
  - load_req is ignored while in LOAD. ir holds and ir_valid=0.
- load_ovf and parity_err clear only on res.
- Fetch and write never coincide, so no read-during-write case exists.

## Timing
- Reset values: ir=0, ir_valid=0, ld_ready=0, busy=1, load_ovf=0, parity_err=0.
- busy=1 for CMD_CNT cycles after the cycle res is deasserted, then 0.
- Fetch latency is 1 cycle: pc/fetch_en sampled at edge N, ir/ir_valid valid after edge N.
- Back-to-back fetches run at one per cycle.
- ld_ready asserts the cycle after load_req is sampled in IDLE.
- ld_ready deasserts the cycle after the terminating byte (ld_last or overflow) is accepted.
- busy falls together with ld_ready. The first fetch is possible on the next edge.
- The word write occurs on the same edge that accepts the completing byte.
- Reset mid-LOAD aborts the session and restarts CLEAR; all words become 0.

## Configuration
- PMEM_PARITY_EN defined:
  - Each word stores one extra even-parity bit, computed at write (CLEAR writes parity 0).
  - On every in-range IDLE fetch, the stored parity is checked. A mismatch sets parity_err on the same edge ir updates.
- PMEM_PARITY_EN undefined: no parity storage or check; parity_err is constant 0.

## Test plan
- Reset with defaults, hold res 3 cycles, release -> busy=1 for exactly 64 cycles. Then fetch pc=5 -> ir=0x0000, ir_valid=1 one cycle later.
- load_req, then bytes 0x49,0x03,0x4A,0x14 (last on 0x14) -> mem[0]=0x4903, mem[1]=0x4A14. Fetch pc=0,1 back-to-back -> ir=0x4903 then 0x4A14 on consecutive cycles.
- Load 0x12,0x34,0xAB with ld_last on 0xAB -> mem[1]=0xAB00, mem[0]=0x1234, mem[2] unchanged. Also toggle ld_valid low between bytes -> no byte lost or duplicated.
- Load 130 bytes without ld_last -> 64 words written; load_ovf=1 and ld_ready=0 after byte 128; bytes 129-130 not accepted. fetch pc=200 -> ir=0x0000.
- Assert res after 3 bytes of a load -> busy=1 for 64 cycles, ld_ready=0, then every fetch pc 0..63 returns 0.
- PMEM_PARITY_EN: load 0x4903, flip a stored data bit via hierarchical force, fetch pc=0 -> parity_err=1 and stays 1 until res. The same fetch without corruption -> parity_err=0.
